// File: rtl/rs_hs_pipeline_relay_pkg.sv
// Shared definitions for the registered handshake relay: stage count
// encodings, depth limit and occupancy width helper.
package rs_hs_pkg;

  localparam int unsigned RS_HS_MAX_DEPTH = 16;

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } rs_cnt_e;

  // A chain of `depth` two-entry stages holds up to 2*depth words.
  function automatic int unsigned rs_occ_width(input int unsigned depth);
    return (depth == 0) ? 1 : $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/rs_hs_pipeline_relay_stage.sv
// One relay stage: a 2-entry buffer whose ready and valid are both registers,
// so no input reaches any output combinationally.
module rs_hs_relay_stage
  import rs_hs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_write,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic                  o_full_n,
  output logic                  o_empty_n,
  input  logic                  i_read,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic [1:0]            o_count
);

  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic                  r_full_n;
  logic                  r_empty_n;
  rs_cnt_e               r_cnt;
  rs_cnt_e               w_cnt_nxt;
  logic                  w_push;
  logic                  w_pop;

  assign w_push = i_write & r_full_n;
  assign w_pop  = i_read & r_empty_n;

  always_comb begin
    w_cnt_nxt = r_cnt;
    case (r_cnt)
      CNT_EMPTY: if (w_push) w_cnt_nxt = CNT_ONE;
      CNT_ONE: begin
        if (w_push && !w_pop)      w_cnt_nxt = CNT_FULL;
        else if (w_pop && !w_push) w_cnt_nxt = CNT_EMPTY;
      end
      CNT_FULL:  if (w_pop) w_cnt_nxt = CNT_ONE;
      default:   w_cnt_nxt = CNT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= CNT_EMPTY;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_full_n  <= 1'b0;
      r_empty_n <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) r_mem[i] <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_full_n  <= (w_cnt_nxt != CNT_FULL);
      r_empty_n <= (w_cnt_nxt != CNT_EMPTY);
      if (w_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
    end
  end

  assign o_full_n  = r_full_n;
  assign o_empty_n = r_empty_n;
  assign o_dout    = r_mem[r_rptr];
  assign o_count   = r_cnt;

endmodule

// File: rtl/rs_hs_pipeline_relay.sv
// Fully registered handshake relay: DEPTH chained 2-entry stages between a
// FIFO-style producer and consumer, with live occupancy; DEPTH=0 is a wire.
module rs_hs_pipeline_relay
  import rs_hs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2,
  parameter              __REGION   = "",
  localparam int unsigned OCC_W     = rs_occ_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [OCC_W-1:0]      occupancy
);

  if (DEPTH == 0) begin : g_bypass
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ reset;
    assign if_empty_n = if_write;
    assign if_full_n  = if_read;
    assign if_dout    = if_din;
    assign occupancy  = '0;
  end else begin : g_chain
    logic [DEPTH:0]        w_valid;
    logic [DEPTH:0]        w_ready;
    logic [DATA_WIDTH-1:0] w_data [DEPTH+1];
    logic [1:0]            w_cnt  [DEPTH];
    logic [OCC_W-1:0]      w_occ;

    assign w_valid[0]     = if_write;
    assign w_data[0]      = if_din;
    assign w_ready[DEPTH] = if_read;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      rs_hs_relay_stage #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_stage (
        .clk      (clk),
        .reset    (reset),
        .i_write  (w_valid[k]),
        .i_din    (w_data[k]),
        .o_full_n (w_ready[k]),
        .o_empty_n(w_valid[k+1]),
        .i_read   (w_ready[k+1]),
        .o_dout   (w_data[k+1]),
        .o_count  (w_cnt[k])
      );
    end

    // Sum of stage count registers only: it moves on the same edge as the
    // counts and has no path from any input.
    always_comb begin
      w_occ = '0;
      for (int unsigned k = 0; k < DEPTH; k++) w_occ = w_occ + OCC_W'(w_cnt[k]);
    end

    assign if_full_n  = w_ready[0];
    assign if_empty_n = w_valid[DEPTH];
    assign if_dout    = w_data[DEPTH];
    assign occupancy  = w_occ;
  end

endmodule
